rsa_frame_tx: RTL and testbench
===============================

RSA_FRAME_TX -- requirements
Module: rsa_frame_tx

Interface
REQ-001 Parameter BITLEN, default 256: operand width in bits; SHALL be a multiple of 8, at least 16.
REQ-002 Parameter HDR_BYTE, default 8'h52: frame header byte.
REQ-003 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: single-cycle request to send one frame.
REQ-006 Port n, input, BITLEN: modulus operand.
REQ-007 Port e, input, BITLEN: exponent operand.
REQ-008 Port msg, input, BITLEN: message operand.
REQ-009 Port is_transmitting, input, 1: UART transmitter busy flag.
REQ-010 Port transmit, output, 1: single-cycle UART send strobe.
REQ-011 Port tx_byte, output, 8: byte presented to the UART.
REQ-012 Port busy, output, 1: high from start acceptance until done.
REQ-013 Port done, output, 1: single-cycle frame-complete pulse.
REQ-014 Port tx_err, output, 1: sticky UART handshake timeout flag, cleared by the next accepted start.

Function
REQ-015 Frame SHALL be: HDR_BYTE, then n, then e, then msg, each operand sent MSB byte first; total byte count NB = 1 + 3*BITLEN/8 (97 at default).
REQ-016 start in IDLE SHALL latch {HDR_BYTE, n, e, msg} into a shift register in the same edge, set busy, clear tx_err, and load byte counter with NB.
REQ-017 start while busy SHALL be ignored; latched operands SHALL NOT change mid-frame.
REQ-018 FSM states: IDLE, SEND, WAIT_HI, WAIT_LO, DONE.
REQ-019 SEND: when is_transmitting is low, assert transmit for exactly one cycle with tx_byte = top byte of the shift register, then go to WAIT_HI; if is_transmitting is high, stay in SEND.
REQ-020 WAIT_HI: go to WAIT_LO when is_transmitting is seen high; if not seen within 16 cycles, set tx_err and go to WAIT_LO anyway.
REQ-021 WAIT_LO: when is_transmitting is low, shift register left by 8, decrement counter; go to SEND if counter remains nonzero, else go to DONE.
REQ-022 DONE: assert done for one cycle, deassert busy on the same edge, return to IDLE.
REQ-023 tx_byte SHALL hold its value from the transmit cycle until the next transmit.
REQ-024 Minimum spacing between transmit pulses SHALL be 3 cycles; transmit SHALL never assert in WAIT_HI, WAIT_LO, DONE or IDLE.
REQ-025 Counter width SHALL be clog2(NB+1) bits; no wrap below zero.
REQ-026 start coincident with done SHALL be ignored (FSM is not in IDLE); start is accepted from the following cycle.

Reset
REQ-027 rst SHALL force IDLE immediately, regardless of clock, and abort any frame in progress without a done pulse.
REQ-028 Reset values: transmit=0, tx_byte=8'h00, busy=0, done=0, tx_err=0, counter=0, shift register=0.

Structure
REQ-029 FSM state encodings, HDR_BYTE default and the 16-cycle timeout constant SHALL live in the shared RSA package/include alongside the existing width parameters.
REQ-030 One sub-module is natural: frame_shift_reg (parallel load, left shift by 8, top-byte output).
REQ-031 The block SHALL connect directly to the uart transmit, tx_byte and is_transmitting ports.

Verification
REQ-032 BITLEN=16, n=16'hC35B, e=16'h0011, msg=16'h0041, UART model busy 5 cycles per byte -> tx_byte sequence 52 C3 5B 00 11 00 41, then one done pulse.
REQ-033 Second start pulse asserted mid-frame -> ignored; exactly 7 bytes sent; operands unchanged.
REQ-034 UART model never raises is_transmitting -> tx_err=1 after 16 cycles per byte; frame still completes with done.
REQ-035 rst asserted after the 3rd byte -> all outputs at reset values immediately, no done; a new start then sends the full frame from 52.
REQ-036 is_transmitting held high when start arrives -> first transmit delayed until it falls; no lost bytes.
REQ-037 BITLEN=256 random operands, loopback through uart and serial_to_parallel -> received n, e and message match the sent values; 97 transmit pulses.

Source files
------------

// File: rtl/rsa_frame_tx_pkg.sv
// Shared constants and types for the RSA operand frame transmitter.
// Holds the operand width default, header byte, handshake timeout and FSM encoding.
package rsa_frame_tx_pkg;
    localparam int DEF_BITLEN = 256;
    localparam logic [7:0] DEF_HDR_BYTE = 8'h52;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DONE
    } tx_state_t;

    // Header byte plus three operands, counted in bytes.
    function automatic int frame_bytes(input int bitlen);
        return 1 + 3 * (bitlen / 8);
    endfunction
endpackage

// File: rtl/rsa_frame_tx_shift.sv
// Frame shift register: parallel load, left shift by one byte, top byte exposed.
module frame_shift_reg #(
    parameter int WIDTH = 776
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [7:0]       top_byte
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = din;
        end else if (shift) begin
            data_d = {data_q[WIDTH-9:0], 8'h00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign top_byte = data_q[WIDTH-1 -: 8];
endmodule

// File: rtl/rsa_frame_tx.sv
// Sends {HDR_BYTE, n, e, msg} MSB byte first over a transmit/is_transmitting UART handshake.
module rsa_frame_tx
    import rsa_frame_tx_pkg::*;
#(
    parameter int         BITLEN   = DEF_BITLEN,
    parameter logic [7:0] HDR_BYTE = DEF_HDR_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BITLEN-1:0] n,
    input  logic [BITLEN-1:0] e,
    input  logic [BITLEN-1:0] msg,
    input  logic              is_transmitting,
    output logic              transmit,
    output logic [7:0]        tx_byte,
    output logic              busy,
    output logic              done,
    output logic              tx_err
);
    localparam int NB    = frame_bytes(BITLEN);
    localparam int FW    = 8 * NB;
    localparam int CNT_W = $clog2(NB + 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             transmit_q, transmit_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tx_err_q, tx_err_d;
    logic             sr_load;
    logic             sr_shift;
    logic [7:0]       sr_top;

    frame_shift_reg #(.WIDTH(FW)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (sr_load),
        .shift    (sr_shift),
        .din      ({HDR_BYTE, n, e, msg}),
        .top_byte (sr_top)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        transmit_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_err_d   = tx_err_q;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_load  = 1'b1;
                    busy_d   = 1'b1;
                    tx_err_d = 1'b0;
                    cnt_d    = CNT_W'(NB);
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!is_transmitting) begin
                    transmit_d = 1'b1;
                    tx_byte_d  = sr_top;
                    tmo_d      = '0;
                    state_d    = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                // A UART that never acknowledges must not stall the frame forever.
                if (is_transmitting) begin
                    state_d = ST_WAIT_LO;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    tx_err_d = 1'b1;
                    state_d  = ST_WAIT_LO;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!is_transmitting) begin
                    sr_shift = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (cnt_q > CNT_W'(1)) begin
                        state_d = ST_SEND;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            transmit_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            transmit_q <= transmit_d;
            tx_byte_q  <= tx_byte_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_err_q   <= tx_err_d;
        end
    end

    assign transmit = transmit_q;
    assign tx_byte  = tx_byte_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tx_err   = tx_err_q;
endmodule

// File: tb/tb_rsa_frame_tx.sv
// Directed and random frame checks for rsa_frame_tx against a byte-list reference model.
module tb_rsa_frame_tx;
    localparam int BL  = 16;
    localparam int BLB = 256;
    localparam logic [7:0] HDR = 8'h52;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // DUT A: narrow operands, configurable UART model
    logic          a_start = 1'b0;
    logic [BL-1:0] a_n = '0, a_e = '0, a_msg = '0;
    logic          a_is_tx, a_tx, a_busy, a_done, a_err;
    logic [7:0]    a_byte;

    rsa_frame_tx #(.BITLEN(BL), .HDR_BYTE(HDR)) dut_a (
        .clk (clk), .rst (rst), .start (a_start),
        .n (a_n), .e (a_e), .msg (a_msg),
        .is_transmitting (a_is_tx), .transmit (a_tx), .tx_byte (a_byte),
        .busy (a_busy), .done (a_done), .tx_err (a_err)
    );

    // DUT B: full-width operands, fixed UART model
    logic           b_start = 1'b0;
    logic [BLB-1:0] b_n = '0, b_e = '0, b_msg = '0;
    logic           b_is_tx, b_tx, b_busy, b_done, b_err;
    logic [7:0]     b_byte;

    rsa_frame_tx #(.BITLEN(BLB), .HDR_BYTE(HDR)) dut_b (
        .clk (clk), .rst (rst), .start (b_start),
        .n (b_n), .e (b_e), .msg (b_msg),
        .is_transmitting (b_is_tx), .transmit (b_tx), .tx_byte (b_byte),
        .busy (b_busy), .done (b_done), .tx_err (b_err)
    );

    // UART models: busy for a fixed number of cycles after each send strobe
    int a_busy_len = 5;
    bit a_never    = 1'b0;
    bit a_force    = 1'b0;
    int a_cnt      = 0;
    int b_cnt      = 0;

    always @(posedge clk) begin
        if (a_tx && !a_never) a_cnt <= a_busy_len;
        else if (a_cnt > 0)   a_cnt <= a_cnt - 1;
        if (b_tx)             b_cnt <= 2;
        else if (b_cnt > 0)   b_cnt <= b_cnt - 1;
    end
    assign a_is_tx = a_force || (a_cnt != 0);
    assign b_is_tx = (b_cnt != 0);

    // Byte capture, done counting and strobe spacing
    byte unsigned a_q[$];
    byte unsigned b_q[$];
    byte unsigned exp_q[$];
    int     a_done_cnt  = 0;
    int     a_space_err = 0;
    longint cyc         = 0;
    longint a_last_tx   = -100;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_tx) begin
            a_q.push_back(a_byte);
            if (cyc - a_last_tx < 3) a_space_err <= a_space_err + 1;
            a_last_tx <= cyc;
        end
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (b_tx) b_q.push_back(b_byte);
    end

    task automatic check(input string tag, input logic [BLB-1:0] obs, input logic [BLB-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference frame: header, then each operand split into bytes, most significant first
    task automatic make_exp(input logic [BL-1:0] n, input logic [BL-1:0] e, input logic [BL-1:0] m);
        logic [BL-1:0] ops[3];
        ops[0] = n; ops[1] = e; ops[2] = m;
        exp_q.delete();
        exp_q.push_back(HDR);
        for (int o = 0; o < 3; o++)
            for (int k = BL/8 - 1; k >= 0; k--)
                exp_q.push_back(8'(ops[o] >> (8 * k)));
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_count"}, a_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < a_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), a_q[i], exp_q[i]);
    endtask

    task automatic send_a(input logic [BL-1:0] n, input logic [BL-1:0] e, input logic [BL-1:0] m);
        a_n = n; a_e = e; a_msg = m;
        a_q.delete();
        make_exp(n, e, m);
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input bit start_on_done);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (a_done) begin
                seen = 1'b1;
                if (start_on_done) begin
                    a_start = 1'b1;
                    @(negedge clk);
                    a_start = 1'b0;
                    check({tag, "_start_on_done_busy"}, a_busy, 0);
                end
            end
        end
        check({tag, "_done_seen"}, seen, 1);
    endtask

    initial begin
        int d0;
        bit reached;
        logic [BL-1:0] rn, re, rm;
        logic [BLB-1:0] wn, we, wm;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_transmit", a_tx, 0);
        check("rst_tx_byte", a_byte, 8'h00);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_tx_err", a_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frame, plus a start coincident with done
        d0 = a_done_cnt;
        send_a(16'hC35B, 16'h0011, 16'h0041);
        check("dir_busy_after_start", a_busy, 1);
        wait_done_a("dir", 1'b1);
        repeat (5) @(negedge clk);
        check_frame("dir");
        check("dir_done_pulses", a_done_cnt - d0, 1);
        check("dir_tx_err", a_err, 0);
        check("dir_idle_after", a_busy, 0);

        // Second start mid-frame with changed operands is ignored
        d0 = a_done_cnt;
        send_a(16'h1234, 16'hABCD, 16'h00FF);
        repeat (15) @(negedge clk);
        a_n = 16'(($urandom)); a_e = 16'(($urandom)); a_msg = 16'(($urandom));
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        wait_done_a("mid", 1'b0);
        repeat (5) @(negedge clk);
        check_frame("mid");
        check("mid_done_pulses", a_done_cnt - d0, 1);

        // UART never acknowledges: timeout sets tx_err, frame still completes
        a_never = 1'b1;
        send_a(16'hBEEF, 16'h0101, 16'h7E7E);
        repeat (10) @(negedge clk);
        check("tmo_err_early", a_err, 0);
        repeat (10) @(negedge clk);
        check("tmo_err_set", a_err, 1);
        wait_done_a("tmo", 1'b0);
        check_frame("tmo");
        check("tmo_err_sticky", a_err, 1);
        a_never = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-frame after the third byte
        d0 = a_done_cnt;
        send_a(16'hC35B, 16'h0011, 16'h0041);
        check("restart_err_cleared", a_err, 0);
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(posedge clk);
            if (a_q.size() >= 3) reached = 1'b1;
        end
        check("rst3_reached", reached, 1);
        @(negedge clk); #2 rst = 1'b1; #1;
        check("rst3_transmit", a_tx, 0);
        check("rst3_tx_byte", a_byte, 8'h00);
        check("rst3_busy", a_busy, 0);
        check("rst3_done", a_done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rst3_no_done", a_done_cnt - d0, 0);
        send_a(16'hC35B, 16'h0011, 16'h0041);
        wait_done_a("rst3_new", 1'b0);
        check_frame("rst3_new");

        // UART busy when start arrives: first strobe waits for it to clear
        a_force = 1'b1;
        send_a(16'h5A5A, 16'h0F0F, 16'hF00D);
        repeat (10) @(negedge clk);
        check("hold_no_tx", a_q.size(), 0);
        check("hold_busy", a_busy, 1);
        a_force = 1'b0;
        wait_done_a("hold", 1'b0);
        check_frame("hold");

        // Random operands and UART latencies
        for (int f = 0; f < 5; f++) begin
            a_busy_len = int'($urandom_range(1, 6));
            rn = 16'($urandom); re = 16'($urandom); rm = 16'($urandom);
            send_a(rn, re, rm);
            wait_done_a($sformatf("rnd%0d", f), 1'b0);
            check_frame($sformatf("rnd%0d", f));
            $display("frame rnd%0d n=%h e=%h msg=%h busy_len=%0d bytes=%0d", f, rn, re, rm, a_busy_len, a_q.size());
        end
        check("spacing_violations", a_space_err, 0);

        // Full-width loopback: rebuild operands from the received bytes
        for (int w = 0; w < 8; w++) begin
            wn[32*w +: 32] = $urandom; we[32*w +: 32] = $urandom; wm[32*w +: 32] = $urandom;
        end
        b_n = wn; b_e = we; b_msg = wm;
        b_q.delete();
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 4000 && !reached; i++) begin
            @(negedge clk);
            if (b_done) reached = 1'b1;
        end
        check("wide_done_seen", reached, 1);
        repeat (2) @(negedge clk);
        check("wide_count", b_q.size(), 97);
        if (b_q.size() == 97) begin
            logic [BLB-1:0] xn, xe, xm;
            xn = '0; xe = '0; xm = '0;
            for (int k = 0; k < 32; k++) begin
                xn = {xn[BLB-9:0], b_q[1 + k]};
                xe = {xe[BLB-9:0], b_q[33 + k]};
                xm = {xm[BLB-9:0], b_q[65 + k]};
            end
            check("wide_hdr", b_q[0], HDR);
            check("wide_n", xn, wn);
            check("wide_e", xe, we);
            check("wide_msg", xm, wm);
        end
        check("wide_tx_err", b_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
